sync_coupled_oscillator: RTL and testbench
==========================================

// Module: sync_coupled_oscillator
// PURPOSE
//  Clocked, parametrised successor to the free-running coupled oscillator cell.
//  Phase is a PHASE_W-bit accumulator advanced every clk by BASE_STEP plus a
//  signed coupling term formed from N neighbour inputs and latched weights.
//  Adds run control, freeze, a programmable initial phase and period measurement.
//  Tiles as one Ising spin; out feeds neighbours' coupling_inputs.
// PARAMETERS
//  N          3   number of coupling inputs
//  WEIGHT_W   3   width of each signed two's-complement weight
//  PHASE_W    8   phase accumulator width; out = phase MSB
//  BASE_STEP  8   uncoupled phase increment per cycle, 1..2^(PHASE_W-1)-1
//  PERIOD_W   12  width of the period measurement counter
// PORTS
//  clk               in   1            system clock
//  rst               in   1            asynchronous reset, active-high
//  start             in   1            pulse: load init_phase, enter RUN
//  freeze            in   1            level: hold phase while in RUN
//  load_weights      in   1            pulse: latch coupling_weights
//  coupling_weights  in   N*WEIGHT_W   weight i at [i*WEIGHT_W +: WEIGHT_W]
//  coupling_inputs   in   N            neighbour outs, synchronous to clk
//  init_phase        in   PHASE_W      phase loaded on start
//  out               out  1            oscillator output, phase[PHASE_W-1]
//  phase             out  PHASE_W      current phase register
//  running           out  1            high in RUN or FROZEN
//  period            out  PERIOD_W     cycles between last two rising edges of out
//  period_valid      out  1            1-cycle pulse when period updates
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, out=0, running=0, period=0, period_valid=0,
//   weight regs=0. Reset mid-operation aborts immediately to these values.
//  States: IDLE -start-> RUN. RUN -freeze-> FROZEN. FROZEN -!freeze-> RUN.
//   start in any state: phase<=init_phase, period counter cleared, state
//   RUN or FROZEN (per freeze), no period_valid that cycle. Start beats freeze.
//  Coupling: c = sum_i (coupling_inputs[i] ? w_i : -w_i), computed in
//   SUM_W = WEIGHT_W+$clog2(N)+1 bits signed. No overflow is possible.
//  Step: s = BASE_STEP + (out ? -c : c), clamped to [1, 2^(PHASE_W-1)-1].
//  RUN: phase <= phase + s, mod 2^PHASE_W (natural wrap). IDLE/FROZEN: phase held.
//  out is the registered MSB of phase (same register; zero extra latency).
//  Weights: used only from latched regs. load_weights latches on that clk edge.
//   New weights affect the step computed in the next cycle. Legal in any state.
//  Period: counter increments each RUN cycle, saturates at 2^PERIOD_W-1, and
//   holds in FROZEN. On an out 0->1 transition: if a prior rising edge has
//   occurred since start, then period <= count+1 and period_valid=1.
//   The counter then restarts at 0. The first rising edge after start only
//   arms measurement. Saturated count is reported as all-ones.
//  coupling_inputs with X are not tolerated; the caller guarantees known values.
// STRUCTURE
//  osc_pkg: state enum {IDLE,RUN,FROZEN}; SUM_W function; clamp limits
//   as functions of PHASE_W.
//  Sub-module coupling_sum: combinational signed sum of N masked weights,
//   parameters N, WEIGHT_W. Top holds FSM, phase, weight and period regs.
// TESTING (N=3, WEIGHT_W=3, PHASE_W=8, BASE_STEP=8)
//  Reset, zero weights, start with init_phase=0 -> out toggles every 16 cycles.
//   First period_valid fires on the 2nd rising edge with period=32.
//  Weights all +1, inputs 3'b111 -> c=3. s=11 while out=0, s=5 while out=1.
//   Phase trace matches the model; period settles to the model value.
//  Weights {+3,+3,+3}, inputs 3'b000, out=0 -> s=8-9 clamps to 1.
//   Weights {-4,-4,-4}, inputs 3'b000 -> c=12, s=20.
//  freeze high 10 cycles mid-RUN -> phase and out held, period count held.
//   Then release: measured period is 10 cycles shorter than wall-clock.
//  load_weights at cycle k -> step changes at cycle k+1, not k.
//   start and freeze in the same cycle -> phase=init_phase, state FROZEN.
//  rst asserted between clk edges mid-RUN -> all outputs 0 immediately.
//   No period_valid follows until two rising edges after a new start.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types and sizing helpers for the clocked coupled oscillator.
// Exports the FSM state enum, the coupling-sum width and step clamp limits.
package osc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } osc_state_t;

  // Signed width that holds a sum of n weights of width ww without overflow.
  function automatic int sum_w(input int n, input int ww);
    return ww + $clog2(n) + 1;
  endfunction

  function automatic int step_min(input int pw);
    return (pw > 0) ? 1 : 1;
  endfunction

  // Largest step that still lets the MSB be seen high for at least a cycle.
  function automatic int step_max(input int pw);
    return (1 << (pw - 1)) - 1;
  endfunction

endpackage

// File: rtl/coupling_sum.sv
// Combinational signed sum of N weights, each added or subtracted per input.
// Ports: weights (packed N*WEIGHT_W), inputs (N), sum (SUM_W signed).
module coupling_sum
  import osc_pkg::*;
#(
  parameter int N        = 3,
  parameter int WEIGHT_W = 3,
  parameter int SUM_W    = sum_w(N, WEIGHT_W)
) (
  input  logic [N*WEIGHT_W-1:0] weights,
  input  logic [N-1:0]          inputs,
  output logic [SUM_W-1:0]      sum
);

  always_comb begin
    logic [SUM_W-1:0] w_ext;
    sum   = '0;
    w_ext = '0;
    for (int i = 0; i < N; i++) begin
      w_ext = {{(SUM_W-WEIGHT_W){weights[i*WEIGHT_W+WEIGHT_W-1]}},
               weights[i*WEIGHT_W +: WEIGHT_W]};
      sum = inputs[i] ? sum + w_ext : sum - w_ext;
    end
  end

endmodule

// File: rtl/sync_coupled_oscillator.sv
// Clocked coupled phase oscillator with run control, freeze and period meter.
// Ports: clk, rst, start, freeze, load_weights, coupling_weights,
//   coupling_inputs, init_phase -> out, phase, running, period, period_valid.
module sync_coupled_oscillator
  import osc_pkg::*;
#(
  parameter int N         = 3,
  parameter int WEIGHT_W  = 3,
  parameter int PHASE_W   = 8,
  parameter int BASE_STEP = 8,
  parameter int PERIOD_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  freeze,
  input  logic                  load_weights,
  input  logic [N*WEIGHT_W-1:0] coupling_weights,
  input  logic [N-1:0]          coupling_inputs,
  input  logic [PHASE_W-1:0]    init_phase,
  output logic                  out,
  output logic [PHASE_W-1:0]    phase,
  output logic                  running,
  output logic [PERIOD_W-1:0]   period,
  output logic                  period_valid
);

  localparam int SUM_W  = sum_w(N, WEIGHT_W);
  localparam int STEP_W = ((PHASE_W > SUM_W) ? PHASE_W : SUM_W) + 2;

  localparam logic signed [STEP_W-1:0] S_MIN =
    STEP_W'(step_min(PHASE_W));
  localparam logic signed [STEP_W-1:0] S_MAX =
    STEP_W'(step_max(PHASE_W));
  localparam logic signed [STEP_W-1:0] S_BASE =
    STEP_W'(BASE_STEP);

  osc_state_t            state;
  logic [N*WEIGHT_W-1:0] w_q;
  logic [PERIOD_W-1:0]   cnt;
  logic                  armed;

  logic [SUM_W-1:0]         c;
  logic signed [STEP_W-1:0] c_ext;
  logic signed [STEP_W-1:0] raw;
  logic signed [STEP_W-1:0] step;
  logic [PHASE_W-1:0]       next_phase;
  logic                     rise;
  logic [PERIOD_W-1:0]      cnt_inc;

  coupling_sum #(
    .N        (N),
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W)
  ) u_sum (
    .weights (w_q),
    .inputs  (coupling_inputs),
    .sum     (c)
  );

  assign out     = phase[PHASE_W-1];
  assign running = (state != IDLE);

  // Coupling pushes the phase forward while low, back while high.
  always_comb begin
    c_ext = {{(STEP_W-SUM_W){c[SUM_W-1]}}, c};
    raw   = out ? S_BASE - c_ext : S_BASE + c_ext;
    if (raw < S_MIN)
      step = S_MIN;
    else if (raw > S_MAX)
      step = S_MAX;
    else
      step = raw;
    next_phase = phase + step[PHASE_W-1:0];
    rise       = ~phase[PHASE_W-1] & next_phase[PHASE_W-1];
    cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      w_q          <= '0;
      cnt          <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (load_weights)
        w_q <= coupling_weights;
      if (start) begin
        phase <= init_phase;
        cnt   <= '0;
        armed <= 1'b0;
        state <= freeze ? FROZEN : RUN;
      end else begin
        unique case (1'b1)
          (state == RUN): begin
            phase <= next_phase;
            if (rise) begin
              if (armed) begin
                period       <= cnt_inc;
                period_valid <= 1'b1;
              end
              armed <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
            state <= freeze ? FROZEN : RUN;
          end
          (state == FROZEN): begin
            if (!freeze)
              state <= RUN;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_coupled_oscillator.sv
// Self-checking bench for sync_coupled_oscillator against a numeric model.
// Directed scenarios plus a randomized run, one summary line at the end.
module tb_sync_coupled_oscillator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        freeze = 1'b0;
  logic        load_weights = 1'b0;
  logic [8:0]  coupling_weights = '0;
  logic [2:0]  coupling_inputs = '0;
  logic [7:0]  init_phase = '0;
  logic        out;
  logic [7:0]  phase;
  logic        running;
  logic [11:0] period;
  logic        period_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase, m_mode, m_cnt, m_period;
  bit m_armed, m_pv;
  int m_w[3];

  sync_coupled_oscillator dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .freeze           (freeze),
    .load_weights     (load_weights),
    .coupling_weights (coupling_weights),
    .coupling_inputs  (coupling_inputs),
    .init_phase       (init_phase),
    .out              (out),
    .phase            (phase),
    .running          (running),
    .period           (period),
    .period_valid     (period_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_cnt = 0; m_period = 0;
    m_armed = 0; m_pv = 0;
    for (int i = 0; i < 3; i++) m_w[i] = 0;
  endtask

  function automatic logic [8:0] pack_w(int a, int b, int c);
    logic [2:0] x, y, z;
    x = 3'(a); y = 3'(b); z = 3'(c);
    return {z, y, x};
  endfunction

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic tick();
    int c, s, np;
    if (rst) begin
      model_reset();
    end else begin
      c = 0;
      for (int i = 0; i < 3; i++)
        c += coupling_inputs[i] ? m_w[i] : -m_w[i];
      s = 8 + ((m_phase >= 128) ? -c : c);
      if (s < 1) s = 1;
      if (s > 127) s = 127;
      m_pv = 0;
      if (start) begin
        m_phase = init_phase;
        m_cnt = 0;
        m_armed = 0;
        m_mode = freeze ? 2 : 1;
      end else if (m_mode == 1) begin
        np = (m_phase + s) % 256;
        if (m_phase < 128 && np >= 128) begin
          if (m_armed) begin
            m_period = (m_cnt + 1 > 4095) ? 4095 : m_cnt + 1;
            m_pv = 1;
          end
          m_armed = 1;
          m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1 > 4095) ? 4095 : m_cnt + 1;
        end
        m_phase = np;
        m_mode = freeze ? 2 : 1;
      end else if (m_mode == 2) begin
        if (!freeze) m_mode = 1;
      end
      if (load_weights)
        for (int i = 0; i < 3; i++) begin
          m_w[i] = (coupling_weights >> (3*i)) & 7;
          if (m_w[i] >= 4) m_w[i] -= 8;
        end
    end
    @(posedge clk);
    #1;
    n_cmp += 5;
    if (phase !== 8'(m_phase)) begin
      n_bad++;
      $display("FAIL phase t=%0t got %0d want %0d", $time, phase, m_phase);
    end
    if (out !== (m_phase >= 128)) begin
      n_bad++;
      $display("FAIL out t=%0t got %b want %b", $time, out, m_phase >= 128);
    end
    if (running !== (m_mode != 0)) begin
      n_bad++;
      $display("FAIL running t=%0t got %b want %b", $time, running,
               m_mode != 0);
    end
    if (period !== 12'(m_period)) begin
      n_bad++;
      $display("FAIL period t=%0t got %0d want %0d", $time, period,
               m_period);
    end
    if (period_valid !== m_pv) begin
      n_bad++;
      $display("FAIL period_valid t=%0t got %b want %b", $time,
               period_valid, m_pv);
    end
    start = 0;
    load_weights = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_uncoupled();
    int hit;
    hit = -1;
    coupling_weights = '0; load_weights = 1;
    init_phase = 0; start = 1;
    tick();
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (period_valid && hit < 0) hit = k;
    end
    n_cmp += 2;
    if (hit !== 48) begin
      n_bad++;
      $display("FAIL first_pv_cycle got %0d want 48", hit);
    end
    if (period !== 12'd32) begin
      n_bad++;
      $display("FAIL first_period got %0d want 32", period);
    end
  endtask

  task automatic test_plus_one();
    coupling_weights = pack_w(1, 1, 1); load_weights = 1;
    coupling_inputs = 3'b111; init_phase = 0; start = 1;
    tick();
    tick();
    n_cmp++;
    if (phase !== 8'd11) begin
      n_bad++;
      $display("FAIL plus1_step got %0d want 11", phase);
    end
    repeat (200) tick();
  endtask

  task automatic test_clamp();
    coupling_weights = pack_w(3, 3, 3); load_weights = 1;
    coupling_inputs = 3'b000; init_phase = 0; start = 1;
    tick();
    tick();
    n_cmp++;
    if (phase !== 8'd1) begin
      n_bad++;
      $display("FAIL clamp_low got %0d want 1", phase);
    end
    repeat (20) tick();
    coupling_weights = pack_w(-4, -4, -4); load_weights = 1;
    init_phase = 0; start = 1;
    tick();
    tick();
    n_cmp++;
    if (phase !== 8'd20) begin
      n_bad++;
      $display("FAIL neg4_step got %0d want 20", phase);
    end
    repeat (40) tick();
  endtask

  task automatic test_freeze();
    logic [7:0] held;
    coupling_weights = '0; load_weights = 1;
    coupling_inputs = 3'b000; init_phase = 0; start = 1;
    tick();
    repeat (60) tick();
    freeze = 1;
    tick();
    held = phase;
    repeat (9) tick();
    n_cmp++;
    if (phase !== held) begin
      n_bad++;
      $display("FAIL freeze_hold got %0d want %0d", phase, held);
    end
    freeze = 0;
    repeat (80) tick();
  endtask

  task automatic test_load_timing();
    coupling_weights = '0; load_weights = 1;
    coupling_inputs = 3'b000; init_phase = 0; start = 1;
    tick();
    coupling_weights = pack_w(-4, -4, -4); load_weights = 1;
    tick();
    n_cmp++;
    if (phase !== 8'd8) begin
      n_bad++;
      $display("FAIL load_same_cycle got %0d want 8", phase);
    end
    tick();
    n_cmp++;
    if (phase !== 8'd28) begin
      n_bad++;
      $display("FAIL load_next_cycle got %0d want 28", phase);
    end
  endtask

  task automatic test_start_freeze();
    init_phase = 8'h5a; start = 1; freeze = 1;
    tick();
    n_cmp++;
    if (phase !== 8'h5a || running !== 1'b1) begin
      n_bad++;
      $display("FAIL start_freeze got %0h/%b want 5a/1", phase, running);
    end
    tick();
    freeze = 0;
    repeat (10) tick();
  endtask

  task automatic test_async_reset();
    coupling_weights = '0; load_weights = 1;
    init_phase = 8'd40; start = 1;
    tick();
    repeat (30) tick();
    #3;
    rst = 1;
    #1;
    n_cmp++;
    if ({out, phase, running, period, period_valid} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got %b/%0d/%b/%0d/%b want all 0",
               out, phase, running, period, period_valid);
    end
    model_reset();
    tick();
    rst = 0;
    tick();
    init_phase = 0; start = 1;
    tick();
    repeat (60) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      coupling_inputs = 3'($urandom);
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ($urandom_range(0, 19) == 0) begin
        coupling_weights = 9'($urandom);
        load_weights = 1;
      end
      if ($urandom_range(0, 199) == 0) begin
        init_phase = 8'($urandom);
        start = 1;
      end
      tick();
    end
    freeze = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_uncoupled();
    test_plus_one();
    test_clamp();
    test_freeze();
    test_load_timing();
    test_start_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
